// File: rtl/serializer_pkg.sv
// Shared types for the bit-serial transmitter.
// Two-state FSM: IDLE waits for a held word, SHIFT drives bits.
package serializer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter with a one-word holding register so that
// consecutive words stream out with no idle bit slots between them.
module serializer
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_en,
  output logic                  o_data,
  output logic                  o_wen,
  output logic                  o_last,
  output logic                  o_busy,
  output state_t                o_dbg_state
);

  localparam int              CW      = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DATA_WIDTH - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;

  logic accept;
  logic shift_en;
  logic last_bit;
  logic load;
  logic serial_bit;

  // Handshake: a word transfers on any rising edge where i_valid && o_ready;
  // o_ready depends only on the hold register and reset, never on i_valid/i_en.
  assign o_ready = !hold_full_q && !i_rst;
  assign accept  = i_valid && o_ready;

  assign serial_bit = MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    o_wen       = 1'b0;
    o_last      = 1'b0;
    o_data      = 1'b0;

    shift_en = (state_q == SHIFT) && i_en;
    last_bit = shift_en && (cnt_q == CNT_MAX);
    load     = hold_full_q && ((state_q == IDLE) || last_bit);

    if (state_q == SHIFT) begin
      o_wen  = i_en;
      o_last = last_bit;
      o_data = serial_bit;
    end

    if (shift_en) begin
      cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
      shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    end

    // Loading on the last bit slot is what removes the gap between words.
    if (load) begin
      shreg_d     = hold_q;
      cnt_d       = '0;
      state_d     = SHIFT;
      hold_full_d = 1'b0;
    end else if (last_bit) begin
      state_d = IDLE;
    end

    if (accept) begin
      hold_d      = i_data;
      hold_full_d = 1'b1;
    end
  end

  assign o_busy      = (state_q == SHIFT) || hold_full_q;
  assign o_dbg_state = state_q;

  a_cnt_bound: assert property (@(posedge i_clk) disable iff (i_rst) cnt_q <= CNT_MAX);
  a_last_wen:  assert property (@(posedge i_clk) disable iff (i_rst) o_last |-> o_wen);

endmodule
